mips_multicycle_controller: RTL
===============================

MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 The block SHALL have one parameter: TRAP_ON_OVF, default 1; 1 = signed overflow suppresses register writeback.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports opcode and funct, input, 6 each: instruction fields from the instruction register.
REQ-005 The block SHALL have ports zero and overflow, input, 1 each: ALU flags.
REQ-006 The block SHALL have mem_req (output, 1) and mem_ready (input, 1): the memory handshake; mem_ready is sampled only while mem_req=1.
REQ-007 The block SHALL have these outputs: pc_write, ir_write, reg_write, mem_write, iord, reg_dst, mem_to_reg and alu_src_a (1 each); alu_src_b and pc_src (2 each); alu_control (4).
REQ-008 The block SHALL have outputs ovf_exc and illegal_instr, 1 each: one-cycle event pulses.

Function
REQ-009 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, ALUWB, BRANCH, IMMEXEC, IMMWB and JUMP.
REQ-010 alu_control SHALL use these codes: AND 0000, OR 0001, XOR 0010, NOR 0011, ADDU 0100, ADD 0101, SUBU 0110, SUB 0111, SLT 1000, SLL 1001, SRL 1010, SRA 1011.
REQ-011 FETCH SHALL drive: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADDU, pc_src=00.
REQ-012 In FETCH, ir_write and pc_write SHALL be 1 only in the cycle where mem_ready=1; the FSM then moves to DECODE, otherwise it stays in FETCH.
REQ-013 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and ADDU (branch target) and SHALL select the next state by opcode:
- 0x23 or 0x2B -> MEMADR
- 0x00 -> REXEC
- 0x04 or 0x05 -> BRANCH
- 0x08 or 0x0D -> IMMEXEC
- 0x02 -> JUMP
- any other opcode -> FETCH, with illegal_instr pulsed.
REQ-014 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and ADDU, then go to MEMRD for lw or MEMWR for sw.
REQ-015 MEMRD and MEMWR SHALL hold mem_req=1 and iord=1 until mem_ready=1.
- MEMWR: mem_write=1 only in the cycle where mem_ready=1; then go to FETCH.
- MEMRD: on mem_ready=1, go to MEMWB.
REQ-016 MEMWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-017 REXEC SHALL drive alu_src_a=1 and alu_src_b=00, and SHALL derive alu_control from funct: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA.
- An unlisted funct SHALL go to FETCH with illegal_instr pulsed.
- A listed funct SHALL go to ALUWB.
REQ-018 IMMEXEC SHALL drive alu_src_a=1, alu_src_b=10, and alu_control ADD for addi or OR for ori, then go to IMMWB.
REQ-019 REXEC and IMMEXEC SHALL register the overflow input into ovf_q; ovf_q SHALL be 0 whenever alu_control is not ADD or SUB.
REQ-020 ALUWB (reg_dst=1) and IMMWB (reg_dst=0) SHALL drive mem_to_reg=0 and reg_write = !(ovf_q && TRAP_ON_OVF).
- They SHALL pulse ovf_exc when ovf_q=1.
- Both SHALL then go to FETCH.
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, SUBU and pc_src=01.
- pc_write SHALL be 1 when zero=1 for beq, or zero=0 for bne.
- The FSM SHALL then go to FETCH.
REQ-022 JUMP SHALL drive pc_src=10 and pc_write=1, then go to FETCH.
REQ-023 Every output not listed for a state SHALL be 0, except alu_control, which SHALL default to ADDU.
REQ-024 Instruction latency SHALL be, with zero memory wait states: lw 5 cycles; sw, R-type and immediate 4; beq/bne and j 3.
REQ-025 Each cycle that mem_ready=0 while waiting SHALL add exactly one cycle to that latency.

Reset
REQ-026 On a clock edge with rst=1, the state SHALL become FETCH and ovf_q SHALL become 0.
REQ-027 While rst=1, pc_write, ir_write, reg_write, mem_write, mem_req, ovf_exc and illegal_instr SHALL be forced to 0, including mid-handshake.
REQ-028 The first fetch SHALL begin in the cycle after rst deasserts.

Structure
REQ-029 A shared package mips_pkg SHALL hold the opcode, funct and alu_control localparams and the FSM state encoding.
REQ-030 The funct-to-alu_control mapping SHALL be a combinational sub-module, alu_decoder, with inputs funct and alu_op[1:0] and outputs alu_control and funct_valid.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- add with 0x7FFFFFFF+1: overflow=1 in REXEC -> ovf_exc pulse in ALUWB, reg_write=0; with TRAP_ON_OVF=0 -> reg_write=1.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMRD -> total 10 cycles; ir_write and reg_write each high exactly one cycle.
- beq with zero=1 -> pc_write=1 in BRANCH; bne with zero=1 -> pc_write=0; both return to FETCH.
- opcode 0x3F -> illegal_instr pulse in DECODE, FETCH next, no write enables; R-type with funct 0x3F -> same response from REXEC.
- rst asserted in MEMWR with mem_ready=1 -> mem_write=0 in that cycle; state FETCH after the edge.
- Every listed funct -> alu_control matches the REQ-010 code.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU control codes, ALU-op selector and FSM state encoding.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] F_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] F_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] F_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] F_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] F_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] F_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] F_SLT  = 6'h2A;

    localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_XOR  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_NOR  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALU_ADDU = 4'b0100;
    localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0101;
    localparam logic [ALUC_W-1:0] ALU_SUBU = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALUC_W-1:0] ALU_SLL  = 4'b1001;
    localparam logic [ALUC_W-1:0] ALU_SRL  = 4'b1010;
    localparam logic [ALUC_W-1:0] ALU_SRA  = 4'b1011;

    // alu_op selects a fixed operation or decoding of the funct field
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: instruction fields, ALU flags,
// memory handshake and all datapath control strobes.
interface mips_multicycle_controller_if;
    import mips_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               overflow;
    logic               mem_req;
    logic               mem_ready;
    logic               pc_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_write;
    logic               iord;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_src;
    logic [ALUC_W-1:0]  alu_control;
    logic               ovf_exc;
    logic               illegal_instr;

    modport master (
        input  opcode, funct, zero, overflow, mem_ready,
        output mem_req, pc_write, ir_write, reg_write, mem_write, iord,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               alu_control, ovf_exc, illegal_instr
    );

    modport slave (
        output opcode, funct, zero, overflow, mem_ready,
        input  mem_req, pc_write, ir_write, reg_write, mem_write, iord,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
               alu_control, ovf_exc, illegal_instr
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: fixed ADDU/SUBU or funct-field mapping,
// flagging funct codes that have no ALU operation.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic [ALUC_W-1:0]  alu_control,
    output logic               funct_valid
);

    always_comb begin
        alu_control = ALU_ADDU;
        funct_valid = 1'b1;
        case (alu_op)
            ALUOP_SUBU:  alu_control = ALU_SUBU;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_ADDU:  alu_control = ALU_ADDU;
                    F_SUB:   alu_control = ALU_SUB;
                    F_SUBU:  alu_control = ALU_SUBU;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_XOR:   alu_control = ALU_XOR;
                    F_NOR:   alu_control = ALU_NOR;
                    F_SLT:   alu_control = ALU_SLT;
                    F_SLL:   alu_control = ALU_SLL;
                    F_SRL:   alu_control = ALU_SRL;
                    F_SRA:   alu_control = ALU_SRA;
                    default: funct_valid = 1'b0;
                endcase
            end
            default: alu_control = ALU_ADDU;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback and
// drives datapath strobes from the current state plus handshake/flag inputs.
module mips_multicycle_controller
    import mips_pkg::*;
#(
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  logic clk,
    input  logic rst,
    mips_multicycle_controller_if.master bus
);

    state_t state_q, state_d;
    logic   ovf_q, ovf_d;

    logic [ALUOP_W-1:0] alu_op;
    logic [FUNCT_W-1:0] dec_funct;
    logic [ALUC_W-1:0]  dec_aluc;
    logic               funct_valid;

    // Immediate ops reuse the funct decoder with a synthesised funct code
    always_comb begin
        alu_op    = ALUOP_ADDU;
        dec_funct = bus.funct;
        case (state_q)
            S_REXEC:   alu_op = ALUOP_FUNCT;
            S_IMMEXEC: begin
                alu_op    = ALUOP_FUNCT;
                dec_funct = (bus.opcode == OP_ADDI) ? F_ADD : F_OR;
            end
            S_BRANCH:  alu_op = ALUOP_SUBU;
            default:   alu_op = ALUOP_ADDU;
        endcase
    end

    alu_decoder u_alu_decoder (
        .funct       (dec_funct),
        .alu_op      (alu_op),
        .alu_control (dec_aluc),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        ovf_d             = 1'b0;
        bus.mem_req       = 1'b0;
        bus.pc_write      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_src        = 2'b00;
        bus.alu_control   = ALU_ADDU;
        bus.ovf_exc       = 1'b0;
        bus.illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_REXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_ADDI, OP_ORI:  state_d = S_IMMEXEC;
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        bus.illegal_instr = 1'b1;
                        state_d           = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    bus.mem_write = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_REXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = dec_aluc;
                ovf_d = bus.overflow && (dec_aluc == ALU_ADD || dec_aluc == ALU_SUB);
                if (funct_valid) begin
                    state_d = S_ALUWB;
                end else begin
                    bus.illegal_instr = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            S_ALUWB, S_IMMWB: begin
                bus.reg_dst   = (state_q == S_ALUWB);
                bus.reg_write = !(ovf_q && TRAP_ON_OVF);
                bus.ovf_exc   = ovf_q;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = dec_aluc;
                bus.pc_src      = 2'b01;
                bus.pc_write    = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
                state_d         = S_FETCH;
            end
            S_IMMEXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = dec_aluc;
                ovf_d = bus.overflow && (dec_aluc == ALU_ADD || dec_aluc == ALU_SUB);
                state_d         = S_IMMWB;
            end
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset masks every write/request/event strobe, even mid-handshake
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.mem_write     = 1'b0;
            bus.mem_req       = 1'b0;
            bus.ovf_exc       = 1'b0;
            bus.illegal_instr = 1'b0;
        end
    end

endmodule
